// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Types and constants shared between the fetch path and the decoder.
//   fetch_entry_t : one fetched instruction as it travels fetch -> decode
//   NOP_INSTR     : word presented to decode when no instruction is available
// ----------------------------------------------------------------------------
package cpu_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage : cpu_pkg

// File: rtl/instr_fetch_buffer.sv
// ----------------------------------------------------------------------------
// instr_fetch_buffer
// Circular first-word-fall-through queue between the ICache return path and
// the instruction decoder. Decouples fetch from decode stalls and is emptied
// in one cycle on a redirect/exception flush.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset (priority over flush_i)
//   flush_i      discard all entries
//   if_valid_i   fetch presents an instruction
//   if_pc_i      PC of the presented instruction
//   if_instr_i   presented instruction word
//   if_adel_i    fetch address error flag
//   if_ready_o   buffer can accept (not full)
//   id_valid_o   head entry valid
//   id_pc_o      head PC            (0 when empty)
//   id_instr_o   head instruction   (NOP when empty)
//   id_adel_o    head fetch error   (0 when empty)
//   id_stall_i   decoder stall; head is popped when valid and not stalled
//   count_o      occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module instr_fetch_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             if_valid_i,
    input  logic [31:0]      if_pc_i,
    input  logic [31:0]      if_instr_i,
    input  logic             if_adel_i,
    output logic             if_ready_o,
    output logic             id_valid_o,
    output logic [31:0]      id_pc_o,
    output logic [31:0]      id_instr_o,
    output logic             id_adel_o,
    input  logic             id_stall_i,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0] rp_q, rp_d;
    logic [PTR_W:0] wp_q, wp_d;

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   head;

    logic empty;
    logic full;
    logic push;
    logic pop;

    assign empty = (rp_q == wp_q);
    assign full  = (rp_q[PTR_W-1:0] == wp_q[PTR_W-1:0]) &&
                   (rp_q[PTR_W] != wp_q[PTR_W]);

    // Ready comes from the registered pointers only, so a pop in a full cycle
    // cannot open a slot for a same-cycle push.
    assign if_ready_o = ~full;

    assign push = if_valid_i & ~full & ~flush_i & ~rst;
    assign pop  = ~empty & ~id_stall_i & ~flush_i & ~rst;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        rp_d = rp_q;
        wp_d = wp_q;
        if (rst || flush_i) begin
            rp_d = '0;
            wp_d = '0;
        end else begin
            if (pop)  rp_d = rp_q + PTR_ONE;
            if (push) wp_d = wp_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its pre-edge value, independent of statement order.
        if (rst) begin
            rp_q <= '0;
            wp_q <= '0;
        end else begin
            rp_q <= rp_d;
            wp_q <= wp_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are live, and a reset-free array maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q[PTR_W-1:0]] <= '{pc: if_pc_i, instr: if_instr_i, adel: if_adel_i};
        end
    end

    assign head = mem_q[rp_q[PTR_W-1:0]];

    // Empty buffer presents a NOP so an idle or stalled decoder sees no work.
    always_comb begin
        id_valid_o = ~empty;
        id_pc_o    = 32'h0;
        id_instr_o = NOP_INSTR;
        id_adel_o  = 1'b0;
        if (!empty) begin
            id_pc_o    = head.pc;
            id_instr_o = head.instr;
            id_adel_o  = head.adel;
        end
    end

    assign count_o = wp_q - rp_q;

endmodule : instr_fetch_buffer
